// File: rtl/seq_restoring_divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding and
// default operand width.
package seq_restoring_divider_pkg;

    localparam int DIV_WIDTH_DEF = 8;
    localparam int DIV_CNT_W_DEF = $clog2(DIV_WIDTH_DEF);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only if it did not go negative.
module seq_restoring_divider_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;

    always_comb begin
        shifted = {rem_in, next_bit};
        dvs_ext = {2'b00, divisor};
        q_bit   = (shifted >= dvs_ext);
        rem_out = (WIDTH+1)'(q_bit ? (shifted - dvs_ext) : shifted);
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | one restoring iteration per clock, WIDTH clocks total
// DONE  | result held on outputs until out_ready
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inData_A,
    input  logic [WIDTH-1:0] inData_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outData_Q,
    output logic [WIDTH-1:0] outData_R,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] out_q_q, out_q_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] quo_next;

    seq_restoring_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (rem_q),
        .next_bit (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    assign quo_next = WIDTH'({quo_q, step_bit});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        out_q_d     = out_q_q;
        out_r_d     = out_r_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d   = inData_A;
                    dvs_d   = inData_B;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = (inData_B == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = dvd_q << 1;
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    out_q_d     = quo_next;
                    out_r_d     = step_rem[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                // A zero divisor arrives here without a result yet; publish it one clock later.
                if (!out_valid_q) begin
                    out_q_d     = '1;
                    out_r_d     = dvd_q;
                    dbz_d       = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            out_q_q     <= out_q_d;
            out_r_q     <= out_r_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign outData_Q   = out_q_q;
    assign outData_R   = out_r_q;
    assign div_by_zero = dbz_q;

endmodule
